// File: rtl/edge_fetch_sched.sv
// Edge fetch scheduler: arbitrates two requesters and streams a node's successors.
// Optional EDGE_FETCH_PERF_CNT_EN adds a saturating streamed-edge counter.
module edge_fetch_sched #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_COUNTER_WIDTH   = 4,
    parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [1:0]                                    req_valid,
    input  logic [2*PARAM_NODE_IDX_WIDTH-1:0]             req_node_idx,
    output logic [1:0]                                    req_gnt,
    output logic [1:0]                                    resp_valid,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]               resp_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]                resp_counter,
    output logic                                          busy,
    output logic                                          ntab_rd_en,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]               ntab_addr,
    input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] ntab_rdata,
    output logic                                          edge_rd_en,
    output logic [PARAM_EDGE_ADDR_WIDTH-1:0]              edge_addr,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]               edge_rdata,
    output logic [15:0]                                   perf_edge_cnt
);

    localparam int W = PARAM_NODE_IDX_WIDTH;
    localparam int C = PARAM_COUNTER_WIDTH;
    localparam int E = PARAM_EDGE_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TAB_WAIT = 2'd1,
        STREAM   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_gnt_q, last_gnt_d;
    logic [C-1:0]   remain_q, remain_d;
    logic [E-1:0]   eaddr_q, eaddr_d;

    logic           any_req;
    logic           win;
    logic [E-1:0]   tab_base;
    logic [C-1:0]   tab_cnt;
    logic [E-1:0]   eaddr_nxt;
    logic           more;

    assign any_req   = |req_valid;
    assign tab_base  = ntab_rdata[E+C-1:C];
    assign tab_cnt   = ntab_rdata[C-1:0];
    assign eaddr_nxt = eaddr_q + E'(1);
    assign more      = remain_q > C'(1);
    assign busy      = state_q != IDLE;

    // Round-robin: on contention the requester not granted last time wins.
    always_comb begin
        win = 1'b0;
        if (req_valid == 2'b10) begin
            win = 1'b1;
        end else if (req_valid == 2'b11) begin
            win = ~last_gnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            remain_q   <= '0;
            eaddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            remain_q   <= remain_d;
            eaddr_q    <= eaddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        remain_d   = remain_q;
        eaddr_d    = eaddr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = TAB_WAIT;
                    owner_d    = win;
                    last_gnt_d = win;
                end
            end
            TAB_WAIT: begin
                if (tab_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d  = STREAM;
                    remain_d = tab_cnt;
                    eaddr_d  = tab_base;
                end
            end
            STREAM: begin
                if (more) begin
                    remain_d = remain_q - C'(1);
                    eaddr_d  = eaddr_nxt;
                end else begin
                    remain_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_gnt       = '0;
        resp_valid    = '0;
        resp_node_idx = '0;
        resp_counter  = '0;
        ntab_rd_en    = 1'b0;
        ntab_addr     = '0;
        edge_rd_en    = 1'b0;
        edge_addr     = '0;
        unique case (state_q)
            IDLE: begin
                // No grant while reset is held: it would be lost at the edge.
                if (any_req && !rst) begin
                    req_gnt    = win ? 2'b10 : 2'b01;
                    ntab_rd_en = 1'b1;
                    ntab_addr  = win ? req_node_idx[2*W-1:W]
                                     : req_node_idx[W-1:0];
                end
            end
            TAB_WAIT: begin
                if (tab_cnt == '0) begin
                    resp_valid = owner_q ? 2'b10 : 2'b01;
                end else begin
                    edge_rd_en = 1'b1;
                    edge_addr  = tab_base;
                end
            end
            STREAM: begin
                resp_valid    = owner_q ? 2'b10 : 2'b01;
                resp_node_idx = edge_rdata;
                resp_counter  = remain_q;
                if (more) begin
                    edge_rd_en = 1'b1;
                    edge_addr  = eaddr_nxt;
                end
            end
            default: ;
        endcase
    end

`ifdef EDGE_FETCH_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (resp_valid != '0 && resp_counter != '0 && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_edge_cnt = perf_q;
`else
    assign perf_edge_cnt = '0;
`endif

endmodule

// File: tb/tb_edge_fetch_sched.sv
// Directed scoreboard bench for edge_fetch_sched with behavioural table/edge memories.
module tb_edge_fetch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [19:0] req_node_idx = '0;
    logic [1:0]  req_gnt;
    logic [1:0]  resp_valid;
    logic [9:0]  resp_node_idx;
    logic [3:0]  resp_counter;
    logic        busy;
    logic        ntab_rd_en;
    logic [9:0]  ntab_addr;
    logic [15:0] ntab_rdata = '0;
    logic        edge_rd_en;
    logic [11:0] edge_addr;
    logic [9:0]  edge_rdata = '0;
    logic [15:0] perf_edge_cnt;

    edge_fetch_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_node_idx (req_node_idx),
        .req_gnt      (req_gnt),
        .resp_valid   (resp_valid),
        .resp_node_idx(resp_node_idx),
        .resp_counter (resp_counter),
        .busy         (busy),
        .ntab_rd_en   (ntab_rd_en),
        .ntab_addr    (ntab_addr),
        .ntab_rdata   (ntab_rdata),
        .edge_rd_en   (edge_rd_en),
        .edge_addr    (edge_addr),
        .edge_rdata   (edge_rdata),
        .perf_edge_cnt(perf_edge_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv;
        logic [9:0] node;
        logic [3:0] cnt;
    } beat_t;

    beat_t       sbq[$];
    logic [15:0] ntab_mem [0:1023];
    logic [9:0]  emem [0:4095];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        mon_en = 1'b0;
    int          ea[4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    int          exp_perf;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ntab_rd_en) ntab_rdata <= ntab_mem[ntab_addr];
        if (edge_rd_en) edge_rdata <= emem[edge_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int owner, input int node, input int lim);
        logic [15:0] ent;
        logic [11:0] b;
        logic [11:0] a;
        int          c;
        ent = ntab_mem[node];
        b   = ent[15:4];
        c   = int'(ent[3:0]);
        if (c == 0) begin
            sbq.push_back('{owner != 0 ? 2'b10 : 2'b01, 10'd0, 4'd0});
        end else begin
            for (int i = 0; i < c && i < lim; i++) begin
                a = b + 12'(i);
                sbq.push_back('{owner != 0 ? 2'b10 : 2'b01, emem[a], 4'(c - i)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            beat_t e;
            chk("gnt_onehot", 32'($onehot0(req_gnt)), 1);
            chk("resp_onehot", 32'($onehot0(resp_valid)), 1);
            chk("gnt_resp_overlap", 32'(req_gnt & resp_valid), 0);
            if (!edge_rd_en) chk("edge_addr_idle", 32'(edge_addr), 0);
            if (!ntab_rd_en) chk("ntab_addr_idle", 32'(ntab_addr), 0);
            if (resp_valid != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 32'(resp_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_owner", 32'(resp_valid), 32'(e.rv));
                    chk("beat_node", 32'(resp_node_idx), 32'(e.node));
                    chk("beat_counter", 32'(resp_counter), 32'(e.cnt));
                end
            end else begin
                chk("idle_resp", 32'({resp_node_idx, resp_counter}), 0);
            end
        end
    end

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_gnt(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_gnt == 2'b00 && n < 50);
        chk("gnt_timeout", 32'(req_gnt != 2'b00), 1);
        t = cyc;
    endtask

    task automatic fetch(input int r, input int node, input int lim,
                         output int t);
        @(posedge clk); #1;
        req_valid    = r != 0 ? 2'b10 : 2'b01;
        req_node_idx = r != 0 ? {10'(node), 10'd0} : {10'd0, 10'(node)};
        wait_gnt(t);
        chk("fetch_gnt", 32'(req_gnt), r != 0 ? 2 : 1);
        chk("fetch_ntab_addr", 32'(ntab_addr), 32'(node));
        push_exp(r, node, lim);
        @(posedge clk); #1;
        req_valid    = '0;
        req_node_idx = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 32'(sbq.size()), 0);
        chk("drain_busy", 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outputs", 32'({req_gnt, resp_valid, ntab_rd_en, edge_rd_en}), 0);
        chk("rst_perf", 32'(perf_edge_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t1, t2, tp;
        for (int i = 0; i < 1024; i++) ntab_mem[i] = '0;
        for (int i = 0; i < 4096; i++) emem[i] = '0;
        ntab_mem[5]  = {12'h010, 4'd3};
        emem[12'h010] = 10'd7;
        emem[12'h011] = 10'd8;
        emem[12'h012] = 10'd9;
        ntab_mem[7]  = {12'h123, 4'd0};
        ntab_mem[9]  = {12'hFFE, 4'd4};
        emem[12'hFFE] = 10'd100;
        emem[12'hFFF] = 10'd101;
        emem[12'h000] = 10'd102;
        emem[12'h001] = 10'd103;
        ntab_mem[11] = {12'h300, 4'd5};
        for (int i = 0; i < 5; i++) emem[12'h300 + i] = 10'(200 + i);
        ntab_mem[12] = {12'h400, 4'd15};
        for (int i = 0; i < 15; i++) emem[12'h400 + i] = 10'(300 + i);
        ntab_mem[20] = {12'h100, 4'd1};
        emem[12'h100] = 10'd55;
        ntab_mem[21] = {12'h200, 4'd1};
        emem[12'h200] = 10'd66;

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        // Basic three-successor fetch with latency checks
        fetch(0, 5, 16, t);
        at_neg(t + 1);
        chk("a_tabwait_resp", 32'(resp_valid), 0);
        chk("a_edge_base", 32'({edge_rd_en, edge_addr}), 32'({1'b1, 12'h010}));
        at_neg(t + 2);
        chk("a_first_beat", 32'(resp_valid), 1);
        at_neg(t + 4);
        chk("a_last_beat", 32'(resp_valid), 1);
        at_neg(t + 5);
        chk("a_done_resp", 32'(resp_valid), 0);
        chk("a_done_busy", 32'(busy), 0);
        drain();

        // Round-robin with both requesters held
        do_reset();
        @(posedge clk); #1;
        req_valid    = 2'b11;
        req_node_idx = {10'd21, 10'd20};
        tp = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(t);
            chk("rr_gnt", 32'(req_gnt), (k % 2) != 0 ? 2 : 1);
            if (k > 0) chk("rr_gap", 32'(t - tp), 3);
            push_exp(k % 2, (k % 2) != 0 ? 21 : 20, 16);
            tp = t;
        end
        @(posedge clk); #1;
        req_valid    = '0;
        req_node_idx = '0;
        drain();

        // Zero-successor node, back-to-back grants
        @(posedge clk); #1;
        req_valid    = 2'b10;
        req_node_idx = {10'd7, 10'd0};
        wait_gnt(t1);
        chk("c_gnt", 32'(req_gnt), 2);
        push_exp(1, 7, 16);
        at_neg(t1 + 1);
        chk("c_no_edge_rd", 32'(edge_rd_en), 0);
        chk("c_beat_now", 32'(resp_valid), 2);
        wait_gnt(t2);
        chk("c_next_gnt_gap", 32'(t2 - t1), 2);
        push_exp(1, 7, 16);
        @(posedge clk); #1;
        req_valid    = '0;
        req_node_idx = '0;
        drain();

        // Edge address wraps past the top of edge memory
        fetch(0, 9, 16, t);
        for (int i = 0; i < 4; i++) begin
            at_neg(t + 1 + i);
            chk("d_edge_rd_en", 32'(edge_rd_en), 1);
            chk("d_edge_addr", 32'(edge_addr), 32'(ea[i]));
        end
        at_neg(t + 5);
        chk("d_edge_rd_off", 32'(edge_rd_en), 0);
        drain();

        // Reset in the middle of a five-beat stream
        fetch(0, 11, 2, t);
        at_neg(t + 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        at_neg(t + 4);
        chk("e_busy", 32'(busy), 0);
        chk("e_outputs", 32'({req_gnt, resp_valid, ntab_rd_en, edge_rd_en}), 0);
        chk("e_resp_data", 32'({resp_node_idx, resp_counter}), 0);
        chk("e_perf", 32'(perf_edge_cnt), 0);
        repeat (8) @(negedge clk);
        chk("e_queue", 32'(sbq.size()), 0);

        // Streamed-edge statistic over counts 3, 0, 15
        fetch(0, 5, 16, t);
        drain();
        fetch(1, 7, 16, t);
        drain();
        fetch(0, 12, 16, t);
        drain();
`ifdef EDGE_FETCH_PERF_CNT_EN
        exp_perf = 18;
`else
        exp_perf = 0;
`endif
        @(negedge clk);
        chk("f_perf", 32'(perf_edge_cnt), 32'(exp_perf));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_fetch_sched.md
EDGE_FETCH_SCHED -- requirements
Module: edge_fetch_sched

Interface
REQ-001 SHALL have parameter PARAM_NODE_IDX_WIDTH, default 10, node index width (W).
REQ-002 SHALL have parameter PARAM_COUNTER_WIDTH, default 4, successor count width (C).
REQ-003 SHALL have parameter PARAM_EDGE_ADDR_WIDTH, default 12, edge memory address width (E).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  2  per-requester fetch request, bit r = requester r.
REQ-007 SHALL have port req_node_idx  in  2*W  node to expand; bits [W-1:0] requester 0, [2W-1:W] requester 1.
REQ-008 SHALL have port req_gnt  out  2  one-hot single-cycle accept pulse.
REQ-009 SHALL have port resp_valid  out  2  one-hot, successor beat for owning requester.
REQ-010 SHALL have port resp_node_idx  out  W  successor node index.
REQ-011 SHALL have port resp_counter  out  C  successors remaining including current beat; 1 marks last, 0 marks no successors.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port ntab_rd_en / ntab_addr  out  1 / W  node table read, data returned next cycle.
REQ-014 SHALL have port ntab_rdata  in  E+C  {base[E+C-1:C], count[C-1:0]}.
REQ-015 SHALL have port edge_rd_en / edge_addr  out  1 / E  edge memory read, data returned next cycle.
REQ-016 SHALL have port edge_rdata  in  W  successor node index at edge_addr.
REQ-017 SHALL have port perf_edge_cnt  out  16  streamed-edge statistic (see Configuration).

Function
REQ-018 FSM SHALL have states IDLE, TAB_WAIT, STREAM; req_valid SHALL be sampled only in IDLE.
REQ-019 IDLE with any req_valid: SHALL grant requester r, pulse req_gnt[r], drive ntab_rd_en=1, ntab_addr=req_node_idx[r], latch owner=r, go TAB_WAIT.
REQ-020 Arbitration SHALL be round-robin: single requester wins; both valid -> requester other than last_gnt wins; last_gnt updated on every grant.
REQ-021 Requesters SHALL hold req_valid until req_gnt; deassertion before grant drops the request without side effect.
REQ-022 TAB_WAIT, count==0: SHALL drive resp_valid[owner]=1, resp_counter=0, resp_node_idx=0 for one cycle, go IDLE.
REQ-023 TAB_WAIT, count!=0: SHALL drive edge_rd_en=1, edge_addr=base, load remain=count, go STREAM.
REQ-024 STREAM: SHALL drive resp_valid[owner]=1, resp_node_idx=edge_rdata, resp_counter=remain every cycle; no backpressure.
REQ-025 STREAM, remain>1: SHALL issue edge read at previous edge_addr+1 (mod 2^E), decrement remain, stay; remain==1: go IDLE.
REQ-026 Latency: grant at cycle T -> first beat T+2 (count 0: T+1), last beat T+1+count, next grant no earlier than T+2+count.
REQ-027 Outside active beats resp_valid=0, resp_node_idx=0, resp_counter=0; ntab_addr/edge_addr SHALL be 0 when their rd_en is low.
REQ-028 req_gnt and resp_valid SHALL each have at most one bit set; req_gnt and resp_valid SHALL never pulse for the same requester in the same cycle.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, last_gnt=1 (requester 0 wins first contention), remain=0, owner=0, all outputs 0.
REQ-030 rst mid-TAB_WAIT/STREAM SHALL abort the transfer; no further resp_valid; requester re-requests.

Configuration
REQ-031 Macro EDGE_FETCH_PERF_CNT_EN defined: perf_edge_cnt SHALL be a register incrementing once per cycle with resp_valid!=0 and resp_counter!=0, saturating at 16'hFFFF, cleared by rst.
REQ-032 Macro EDGE_FETCH_PERF_CNT_EN undefined: perf_edge_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 req_valid=01, node 5, table {base 12'h010, count 3}, edges 7,8,9 -> req_gnt=01 at T; resp (7,3),(8,2),(9,1) on resp_valid[0] at T+2..T+4; busy low at T+5.
REQ-034 req_valid=11 held, each node count 1 -> grant order 0,1,0,1 every 3 cycles.
REQ-035 count=0 -> one beat resp_counter=0 at T+1, no edge_rd_en, next grant at T+2.
REQ-036 base 12'hFFE, count 4 -> edge_addr FFE, FFF, 000, 001 on consecutive cycles.
REQ-037 rst at T+3 during count-5 stream -> next cycle IDLE, all outputs 0, no further resp_valid.
REQ-038 Macro defined, three fetches with counts 3,0,15 -> perf_edge_cnt=18; macro undefined -> 0.
